// File: rtl/i2s_voice_scheduler.sv
// i2s_voice_scheduler
// Runs one mixing sequence per stereo frame. Each tx_ready pulse starts a pass
// that polls the voices in order 0..N-1 over a one-hot req/ack handshake. The
// signed left/right samples are summed in wide accumulators and saturated to
// 32 bits. The result is then presented on sample/sample_ready for i2s_tx.
module i2s_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int TIMEOUT    = 6
) (
    input  logic                    sclk,
    input  logic                    aclr,
    input  logic                    tx_ready,
    input  logic [NUM_VOICES-1:0]   voice_en,
    output logic [NUM_VOICES-1:0]   voice_req,
    input  logic [NUM_VOICES-1:0]   voice_ack,
    input  logic [32*NUM_VOICES-1:0] voice_l,
    input  logic [32*NUM_VOICES-1:0] voice_r,
    output logic [63:0]             sample,
    output logic                    sample_ready,
    output logic                    busy,
    output logic                    overrun,
    output logic [NUM_VOICES-1:0]   voice_to,
    input  logic                    clr_status
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    // 3 guard bits: eight full-scale 32-bit samples cannot overflow the sum
    localparam int AW = 35;
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [NUM_VOICES-1:0] ONE_HOT0 = NUM_VOICES'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POLL = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]   req_q, req_d;
    logic [NUM_VOICES-1:0]   en_q, en_d;
    logic signed [AW-1:0]    acc_l_q, acc_l_d;
    logic signed [AW-1:0]    acc_r_q, acc_r_d;
    logic [63:0]             sample_q, sample_d;
    logic                    ready_q, ready_d;
    logic                    overrun_q, overrun_d;
    logic [NUM_VOICES-1:0]   to_q, to_d;

    logic                    advance;
    logic [IW-1:0]           idx_inc;
    logic [31:0]             sel_l, sel_r;

    // Per-voice lanes unpacked from the flat sample buses
    logic [31:0] lane_l [NUM_VOICES];
    logic [31:0] lane_r [NUM_VOICES];

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_lane
        assign lane_l[gi] = voice_l[32*gi +: 32];
        assign lane_r[gi] = voice_r[32*gi +: 32];
    end

    assign sel_l   = lane_l[idx_q];
    assign sel_r   = lane_r[idx_q];
    assign idx_inc = idx_q + 1'b1;

    // Clamp a wide accumulator into the signed 32-bit range
    function automatic logic [31:0] sat32(input logic signed [AW-1:0] a);
        logic [31:0] r;
        if (a[AW-1] && !(&a[AW-2:31]))
            r = 32'h8000_0000;
        else if (!a[AW-1] && (|a[AW-2:31]))
            r = 32'h7FFF_FFFF;
        else
            r = a[31:0];
        return r;
    endfunction

    // Frame sequencer: start/abort, per-voice polling, mix and status flags
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        en_d      = en_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        sample_d  = sample_q;
        ready_d   = ready_q;
        overrun_d = clr_status ? 1'b0 : overrun_q;
        to_d      = clr_status ? '0 : to_q;
        advance   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (tx_ready) begin
                    // New frame; voice 0 is requested on the same edge
                    state_d = POLL;
                    en_d    = voice_en;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    req_d   = voice_en[0] ? ONE_HOT0 : '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            POLL, MIX: begin
                if (tx_ready) begin
                    // Frame did not finish in time: flag it and start over.
                    // All requests drop; voice 0 is re-requested next cycle.
                    overrun_d = 1'b1;
                    state_d   = POLL;
                    en_d      = voice_en;
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    req_d     = '0;
                end else if (state_q == POLL) begin
                    if (!en_q[idx_q]) begin
                        advance = 1'b1;
                    end else if (!req_q[idx_q]) begin
                        // Only after an abort: raise the request first
                        req_d = ONE_HOT0 << idx_q;
                        cnt_d = '0;
                    end else if (voice_ack[idx_q]) begin
                        acc_l_d = acc_l_q + {{(AW-32){sel_l[31]}}, sel_l};
                        acc_r_d = acc_r_q + {{(AW-32){sel_r[31]}}, sel_r};
                        advance = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        to_d[idx_q] = 1'b1;
                        advance     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    sample_d = {sat32(acc_l_q), sat32(acc_r_q)};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Move to the next voice, pre-raising its request so an enabled
        // voice costs no extra setup cycle
        if (advance) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
                state_d = MIX;
                req_d   = '0;
            end else begin
                idx_d = idx_inc;
                req_d = en_q[idx_inc] ? (ONE_HOT0 << idx_inc) : '0;
            end
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge sclk or posedge aclr) begin
        if (aclr) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            req_q     <= '0;
            en_q      <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            en_q      <= en_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            sample_q  <= sample_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            to_q      <= to_d;
        end
    end

    assign voice_req    = req_q;
    assign sample       = sample_q;
    assign sample_ready = ready_q;
    assign busy         = (state_q == POLL) || (state_q == MIX);
    assign overrun      = overrun_q;
    assign voice_to     = to_q;

endmodule
